dc_pio_master: RTL and testbench
================================

Name: dc_pio_master

Overview:
PIO bus master for the ISP1362 device-controller port. It turns one request (command code, direction, word count) from the USB control logic into a command phase followed by 0..N data phases. It sits directly downstream of the USB protocol/interrupt handler and drives the chip's ADDR/CSF/RDF/WRF/DATA pins. It enforces strobe width and inter-access recovery in clock cycles.

Parameters:
STROBE_CLKS, 4, RDF/WRF low time in I_CLK cycles (80 ns at 50 MHz); legal range 1..15
RECOVERY_CLKS, 8, CSF-high cycles between any two phases and after the last phase; legal range 1..31
LEN_W, 8, width of the word-count field; maximum data phases per request is 2**LEN_W-1

Ports:
I_CLK  in  1  system clock, 50 MHz
I_RSTF  in  1  asynchronous reset, active low
I_REQ  in  1  request; held high until O_ACK
I_CMD  in  8  command code, driven on DATA[7:0] during the command phase; DATA[15:8]=0
I_WR  in  1  1 = data phases are writes, 0 = reads
I_LEN  in  LEN_W  number of 16-bit data phases; 0 = command only
I_WDATA  in  16  write word; show-ahead, valid whenever a write is pending
O_WDATA_ACK  out  1  one-cycle pulse: I_WDATA consumed, present the next word
O_RDATA  out  16  read word
O_RDATA_VLD  out  1  one-cycle pulse qualifying O_RDATA
O_ACK  out  1  one-cycle pulse: request accepted, I_CMD/I_WR/I_LEN captured
O_BUSY  out  1  high from the accept cycle through the O_DONE cycle
O_DONE  out  1  one-cycle pulse: transaction complete
O_DC_ADDR  out  2  [1]=1 (DC bus), [0]=1 command phase / 0 data phase
O_DC_CSF  out  1  chip select, active low
O_DC_RDF  out  1  read strobe, active low
O_DC_WRF  out  1  write strobe, active low
IO_DC_DATA  inout  16  data bus; driven only during write and command phases, otherwise Z

Behaviour:
- Reset values: O_DC_CSF=1, O_DC_RDF=1, O_DC_WRF=1, O_DC_ADDR=2'b10, IO_DC_DATA=Z, O_RDATA=0. All pulses and O_BUSY are 0. State is IDLE.
- Reset acts asynchronously, including mid-strobe: the strobes and CSF go high and the bus goes Z immediately. No O_DONE is issued for the aborted transaction.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER, DONE. A phase counter tracks command vs. data phase and the remaining count. A cycle counter times STROBE and RECOVER.
- IDLE: when I_REQ=1, pulse O_ACK, capture fields, go to SETUP. A request is accepted in IDLE only.
- SETUP (1 cycle): CSF=0 and ADDR valid. For a command or write phase, data is driven. For a write data phase, O_WDATA_ACK pulses and I_WDATA is registered.
- STROBE (STROBE_CLKS cycles): WRF=0 for command/write phases, RDF=0 for read phases. CSF, ADDR and data stay stable. For a read, I_DC_DATA is registered on the last strobe cycle.
- HOLD (1 cycle): strobe=1, CSF=0, write data still driven. For a read phase, O_RDATA is updated and O_RDATA_VLD pulses.
- RECOVER (RECOVERY_CLKS cycles): CSF=1, bus Z, ADDR holds its last value. When it ends:
  - if data phases remain, go to SETUP with ADDR[0]=0;
  - otherwise go to DONE.
- DONE (1 cycle): pulse O_DONE, then go to IDLE. The earliest next accept is the cycle after DONE.
- Timing with defaults, accept at cycle T: CSF low T+1..T+6, WRF low T+2..T+5, recovery T+7..T+14, next SETUP or DONE at T+15. Each phase takes 14 cycles; a command-only request has O_DONE at T+15.
- RDF and WRF are never low in the same cycle. A strobe is never low while CSF is high.
- I_LEN=0 with I_WR=1: no O_WDATA_ACK is issued.
- Requests at maximum count (I_LEN = 2**LEN_W-1) complete every phase; the counter does not wrap.

Optional Feature:
DC_PIO_ABORT_EN:
- Defined: adds input I_ABORT (1 bit) and output O_ABORTED (1 bit, pulses with O_DONE).
  - I_ABORT high in any cycle while O_BUSY is set marks an abort. The current phase completes normally through HOLD and RECOVER.
  - No further data phases start, and the block then goes to DONE with O_ABORTED=1.
  - An abort asserted during DONE or IDLE is ignored.
- Undefined: neither port exists, and every request runs all I_LEN phases.

Test Plan:
- Command only: I_CMD=0xF4, I_LEN=0 -> one WRF pulse 4 cycles wide with ADDR=2'b11 and DATA=0x00F4; no data phase; O_DONE at T+15.
- Single write: I_CMD=0xB8, I_WR=1, I_LEN=1, I_WDATA=0x0001 -> command phase, then data phase with ADDR=2'b10 and DATA=0x0001; exactly one O_WDATA_ACK; O_DONE at T+29.
- Single read: I_CMD=0xB5, I_WR=0, I_LEN=1, bus model returns 0x3630 -> one RDF pulse; O_RDATA=0x3630 with O_RDATA_VLD in the HOLD cycle; IO_DC_DATA not driven during RDF low.
- Burst read: I_CMD=0x10, I_LEN=5, model returns 0x0008,0x0680,0x0100,0x0000,0x0020 -> five O_RDATA_VLD pulses in order; CSF high for ≥8 cycles between every phase.
- Back-to-back requests: I_REQ held high across two requests -> second O_ACK exactly 1 cycle after the first O_DONE; recovery is never shortened.
- Reset mid-strobe: I_RSTF low during WRF low -> WRF, CSF and RDF go high asynchronously; bus Z; no O_DONE; the next request runs normally.

Source files
------------

// File: rtl/dc_pio_master.sv
// ISP1362 device-controller PIO master: one request becomes a command phase plus 0..I_LEN data phases.
// Latency: each phase is 1 setup + STROBE_CLKS + 1 hold + RECOVERY_CLKS cycles; O_DONE one cycle after the last recovery.
// Backpressure: I_REQ is held until O_ACK and is only accepted in IDLE; write words are pulled from a show-ahead source via O_WDATA_ACK.
//
// Ports: I_CLK/I_RSTF clock and async active-low reset; I_REQ/I_CMD/I_WR/I_LEN request with O_ACK
// handshake; I_WDATA/O_WDATA_ACK write word source; O_RDATA/O_RDATA_VLD read words;
// O_BUSY/O_DONE transaction status; O_DC_* and IO_DC_DATA drive the chip's PIO pins.
// Optional macro DC_PIO_ABORT_EN adds I_ABORT/O_ABORTED: stop after the current phase.
module dc_pio_master #(
    parameter int STROBE_CLKS   = 4,
    parameter int RECOVERY_CLKS = 8,
    parameter int LEN_W         = 8
) (
    input  logic             I_CLK,
    input  logic             I_RSTF,
    input  logic             I_REQ,
    input  logic [7:0]       I_CMD,
    input  logic             I_WR,
    input  logic [LEN_W-1:0] I_LEN,
    input  logic [15:0]      I_WDATA,
    output logic             O_WDATA_ACK,
    output logic [15:0]      O_RDATA,
    output logic             O_RDATA_VLD,
    output logic             O_ACK,
    output logic             O_BUSY,
    output logic             O_DONE,
`ifdef DC_PIO_ABORT_EN
    input  logic             I_ABORT,
    output logic             O_ABORTED,
`endif
    output logic [1:0]       O_DC_ADDR,
    output logic             O_DC_CSF,
    output logic             O_DC_RDF,
    output logic             O_DC_WRF,
    inout  wire  [15:0]      IO_DC_DATA
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cyc_q, cyc_d;        // counts down the remaining STROBE/RECOVER cycles
    logic [LEN_W-1:0]   remain_q, remain_d;  // data phases not yet started
    logic               cmd_ph_q, cmd_ph_d;  // current phase is the command phase
    logic               wr_q, wr_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               addr0_q, addr0_d;
    logic               csf_q, csf_d;
    logic               rdf_q, rdf_d;
    logic               wrf_q, wrf_d;
    logic               oe_q, oe_d;
    logic [15:0]        dout_q, dout_d;
    logic               stop;
    logic               drive;

`ifdef DC_PIO_ABORT_EN
    logic               abort_q, abort_d;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        remain_d    = remain_q;
        cmd_ph_d    = cmd_ph_q;
        wr_d        = wr_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        O_ACK       = 1'b0;
        O_WDATA_ACK = 1'b0;
        O_RDATA_VLD = 1'b0;
        O_DONE      = 1'b0;
`ifdef DC_PIO_ABORT_EN
        abort_d = abort_q;
        // Aborts only count while a phase sequence is in flight.
        if (I_ABORT && state_q != S_IDLE && state_q != S_DONE) begin
            abort_d = 1'b1;
        end
        stop = abort_d;
`else
        stop = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (I_REQ) begin
                    O_ACK    = 1'b1;
                    state_d  = S_SETUP;
                    cmd_d    = I_CMD;
                    wr_d     = I_WR;
                    remain_d = I_LEN;
                    cmd_ph_d = 1'b1;
`ifdef DC_PIO_ABORT_EN
                    abort_d  = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                O_WDATA_ACK = !cmd_ph_q && wr_q;
                state_d     = S_STROBE;
                cyc_d       = 5'(STROBE_CLKS - 1);
            end
            S_STROBE: begin
                if (cyc_q == 5'd0) begin
                    state_d = S_HOLD;
                    // Sample while RDF is still low; the strobe rises on this same edge.
                    if (!cmd_ph_q && !wr_q) begin
                        rdata_d = IO_DC_DATA;
                    end
                end else begin
                    cyc_d = cyc_q - 5'd1;
                end
            end
            S_HOLD: begin
                O_RDATA_VLD = !cmd_ph_q && !wr_q;
                state_d     = S_RECOVER;
                cyc_d       = 5'(RECOVERY_CLKS - 1);
            end
            S_RECOVER: begin
                if (cyc_q == 5'd0) begin
                    if (remain_q != '0 && !stop) begin
                        state_d  = S_SETUP;
                        remain_d = remain_q - LEN_W'(1);
                        cmd_ph_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cyc_d = cyc_q - 5'd1;
                end
            end
            S_DONE: begin
                O_DONE  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they change cleanly on the clock edge.
        drive   = cmd_ph_d || wr_d;
        csf_d   = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_HOLD);
        wrf_d   = !(state_d == S_STROBE && drive);
        rdf_d   = !(state_d == S_STROBE && !drive);
        oe_d    = !csf_d && drive;
        addr0_d = addr0_q;
        dout_d  = dout_q;
        if (state_d == S_SETUP) begin
            addr0_d = cmd_ph_d;
            dout_d  = cmd_ph_d ? {8'h00, cmd_d} : I_WDATA;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            remain_q <= '0;
            cmd_ph_q <= 1'b0;
            wr_q     <= 1'b0;
            cmd_q    <= '0;
            rdata_q  <= '0;
            addr0_q  <= 1'b0;
            csf_q    <= 1'b1;
            rdf_q    <= 1'b1;
            wrf_q    <= 1'b1;
            oe_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            remain_q <= remain_d;
            cmd_ph_q <= cmd_ph_d;
            wr_q     <= wr_d;
            cmd_q    <= cmd_d;
            rdata_q  <= rdata_d;
            addr0_q  <= addr0_d;
            csf_q    <= csf_d;
            rdf_q    <= rdf_d;
            wrf_q    <= wrf_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
        end
    end

`ifdef DC_PIO_ABORT_EN
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) abort_q <= 1'b0;
        else         abort_q <= abort_d;
    end
    assign O_ABORTED = O_DONE && abort_q;
`endif

    assign O_BUSY     = (state_q != S_IDLE) || O_ACK;
    assign O_RDATA    = rdata_q;
    assign O_DC_ADDR  = {1'b1, addr0_q};
    assign O_DC_CSF   = csf_q;
    assign O_DC_RDF   = rdf_q;
    assign O_DC_WRF   = wrf_q;
    assign IO_DC_DATA = oe_q ? dout_q : 16'hzzzz;

endmodule

// File: tb/tb_dc_pio_master.sv
// Directed bench for dc_pio_master with a simple read-data bus model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dc_pio_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [7:0]  cmd;
    logic        wr;
    logic [7:0]  len;
    logic [15:0] wdata;
    logic        wdata_ack, rdata_vld, ack, busy, done;
    logic [15:0] rdata;
    logic [1:0]  dc_addr;
    logic        dc_csf, dc_rdf, dc_wrf;
    wire  [15:0] dc_data;

    logic [15:0] model [0:7];
    int          vectors = 0;
    int          miscompares = 0;

    // monitor state (owned by the monitor process, cleared on request)
    int clr_seq = 0, clr_seen = 0;
    int cyc, ack_n, ack_cyc, ack2_cyc, done_n, done_cyc, wack_n;
    int wrf_lo_n, rdf_lo_n, csf_lo_n, wrf_run, wrf_max, viol;
    int first_csf, first_wrf, vld_cyc, run, gap_min, tail, rd_n, cmd_addr_n, dat_addr_n;
    logic [15:0] cmd_word, wr_word;
    logic [15:0] rd_words [$];

    always #5 clk = ~clk;

    assign dc_data = (!dc_rdf) ? model[rd_n[2:0]] : 16'hzzzz;

    dc_pio_master dut (
        .I_CLK(clk), .I_RSTF(rst_n), .I_REQ(req), .I_CMD(cmd), .I_WR(wr), .I_LEN(len),
        .I_WDATA(wdata), .O_WDATA_ACK(wdata_ack), .O_RDATA(rdata), .O_RDATA_VLD(rdata_vld),
        .O_ACK(ack), .O_BUSY(busy), .O_DONE(done),
`ifdef DC_PIO_ABORT_EN
        .I_ABORT(1'b0), .O_ABORTED(),
`endif
        .O_DC_ADDR(dc_addr), .O_DC_CSF(dc_csf), .O_DC_RDF(dc_rdf), .O_DC_WRF(dc_wrf),
        .IO_DC_DATA(dc_data)
    );

    always @(negedge clk) begin
        if (clr_seq != clr_seen) begin
            clr_seen = clr_seq;
            cyc = 0; ack_n = 0; ack_cyc = 0; ack2_cyc = 0; done_n = 0; done_cyc = 0;
            wack_n = 0; wrf_lo_n = 0; rdf_lo_n = 0; csf_lo_n = 0; wrf_run = 0; wrf_max = 0;
            viol = 0; first_csf = -1; first_wrf = -1; vld_cyc = -1; run = 0; gap_min = 999;
            tail = 0; rd_n = 0; cmd_addr_n = 0; dat_addr_n = 0; cmd_word = '0; wr_word = '0;
            rd_words.delete();
        end
        cyc++;
        if (ack) begin
            ack_n++;
            if (ack_n == 1) ack_cyc = cyc; else ack2_cyc = cyc;
        end
        if (wdata_ack) wack_n++;
        if (!dc_csf) begin
            csf_lo_n++;
            if (first_csf < 0) first_csf = cyc;
        end
        if (!dc_wrf) begin
            wrf_lo_n++; wrf_run++;
            if (first_wrf < 0) first_wrf = cyc;
            if (dc_addr == 2'b11) begin cmd_word = dc_data; cmd_addr_n++; end
            else if (dc_addr == 2'b10) begin wr_word = dc_data; dat_addr_n++; end
        end else begin
            if (wrf_run > wrf_max) wrf_max = wrf_run;
            wrf_run = 0;
        end
        if (!dc_rdf) rdf_lo_n++;
        if ((!dc_wrf || !dc_rdf) && dc_csf) viol++;
        if (!dc_wrf && !dc_rdf) viol++;
        if (rdata_vld) begin
            rd_words.push_back(rdata);
            if (vld_cyc < 0) vld_cyc = cyc;
            rd_n++;
        end
        // CSF-high run lengths between phases of one transaction
        if (!dc_csf) begin
            if (run != 0 && run < gap_min) gap_min = run;
            run = 0;
        end else if (busy && !ack) begin
            run++;
        end
        if (done) begin
            done_n++;
            if (done_n == 1) done_cyc = cyc;
            tail = run;
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        clr_seq++;
    endtask

    task automatic issue(input logic [7:0] c, input logic w, input logic [7:0] n);
        @(posedge clk); #1;
        req = 1'b1; cmd = c; wr = w; len = n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input int n, input int maxc);
        for (int i = 0; i < maxc && done_n < n; i++) @(negedge clk);
        chk("done_count", 32'(done_n), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; cmd = '0; wr = 1'b0; len = '0; wdata = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_csf", 32'(dc_csf), 32'd1);
        chk("rst_rdf", 32'(dc_rdf), 32'd1);
        chk("rst_wrf", 32'(dc_wrf), 32'd1);
        chk("rst_addr", 32'(dc_addr), 32'h2);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // command only
        clr(); issue(8'hF4, 1'b0, 8'd0); wait_done(1, 60);
        chk("cmd_done_lat", 32'(done_cyc - ack_cyc), 32'd15);
        chk("cmd_csf_start", 32'(first_csf - ack_cyc), 32'd1);
        chk("cmd_wrf_start", 32'(first_wrf - ack_cyc), 32'd2);
        chk("cmd_csf_len", 32'(csf_lo_n), 32'd6);
        chk("cmd_wrf_width", 32'(wrf_max), 32'd4);
        chk("cmd_wrf_addr11", 32'(cmd_addr_n), 32'd4);
        chk("cmd_word", 32'(cmd_word), 32'h00F4);
        chk("cmd_no_wack", 32'(wack_n), 32'd0);
        chk("cmd_no_rdf", 32'(rdf_lo_n), 32'd0);
        chk("cmd_tail_recover", 32'(tail), 32'd9);

        // single write
        clr(); wdata = 16'h0001; issue(8'hB8, 1'b1, 8'd1); wait_done(1, 80);
        chk("wr_done_lat", 32'(done_cyc - ack_cyc), 32'd29);
        chk("wr_wack", 32'(wack_n), 32'd1);
        chk("wr_cmd_word", 32'(cmd_word), 32'h00B8);
        chk("wr_data_word", 32'(wr_word), 32'h0001);
        chk("wr_data_addr10", 32'(dat_addr_n), 32'd4);
        chk("wr_gap", 32'(gap_min), 32'd8);
        chk("wr_viol", 32'(viol), 32'd0);

        // single read
        model[0] = 16'h3630;
        clr(); issue(8'hB5, 1'b0, 8'd1); wait_done(1, 80);
        chk("rd_count", 32'(rd_words.size()), 32'd1);
        if (rd_words.size() > 0) chk("rd_word", 32'(rd_words[0]), 32'h3630);
        chk("rd_vld_cycle", 32'(vld_cyc - ack_cyc), 32'd20);
        chk("rd_rdf_len", 32'(rdf_lo_n), 32'd4);
        chk("rd_wrf_len", 32'(wrf_lo_n), 32'd4);
        chk("rd_rdata_hold", 32'(rdata), 32'h3630);

        // burst read
        model[0] = 16'h0008; model[1] = 16'h0680; model[2] = 16'h0100;
        model[3] = 16'h0000; model[4] = 16'h0020;
        clr(); issue(8'h10, 1'b0, 8'd5); wait_done(1, 200);
        chk("burst_count", 32'(rd_words.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rd_words.size()) chk($sformatf("burst_word%0d", i), 32'(rd_words[i]), 32'(model[i]));
        end
        chk("burst_gap", 32'(gap_min), 32'd8);
        chk("burst_done_lat", 32'(done_cyc - ack_cyc), 32'd85);
        chk("burst_viol", 32'(viol), 32'd0);

        // back-to-back with I_REQ held high
        clr();
        @(posedge clk); #1;
        req = 1'b1; cmd = 8'h21; wr = 1'b0; len = 8'd0;
        for (int i = 0; i < 60 && ack_n < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(2, 60);
        chk("b2b_first_lat", 32'(done_cyc - ack_cyc), 32'd15);
        chk("b2b_reack", 32'(ack2_cyc - done_cyc), 32'd1);
        chk("b2b_tail", 32'(tail), 32'd9);

        // reset in the middle of a strobe
        clr(); wdata = 16'hBEEF; issue(8'h55, 1'b1, 8'd2);
        for (int i = 0; i < 20 && dc_wrf; i++) @(negedge clk);
        chk("mid_wrf_low", 32'(dc_wrf), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wrf_rel", 32'(dc_wrf), 32'd1);
        chk("mid_csf_rel", 32'(dc_csf), 32'd1);
        chk("mid_rdf_rel", 32'(dc_rdf), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_no_done", 32'(done_n), 32'd0);
        clr(); issue(8'h9A, 1'b0, 8'd0); wait_done(1, 60);
        chk("post_done_lat", 32'(done_cyc - ack_cyc), 32'd15);
        chk("post_cmd_word", 32'(cmd_word), 32'h009A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
